// File: rtl/sevseg_scan_ctrl.sv
// rtl/sevseg_scan_ctrl.sv - 4-digit seven-segment scan controller with dead-time blanking and frame-synchronous value update
//
// Purpose:
//   Scans a 4-digit common-anode seven-segment display one digit at a time.
//   Every digit slot is a BLANK phase (all anodes off) followed by a DRIVE
//   phase. New display values are captured into a pending buffer on load and
//   copied into the shadow (displayed) register only at the frame boundary
//   (end of the digit-3 DRIVE slot), so a frame never shows mixed values.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   scan enable; low forces the display dark and idle
//   value[15:0] in   display value, digit k = value[4k+3:4k], digit 0 rightmost
//   load        in   capture value into the pending buffer this cycle
//   dig_en[3:0] in   per-digit enable; 0 keeps that digit dark in its slot
//   upd_pending out  pending value not yet applied to the shadow register
//   frame_done  out  one-cycle pulse during the last cycle of the digit-3 DRIVE slot
//   seg[6:0]    out  active-low segments, seg[6]=g .. seg[0]=a
//   an[3:0]     out  active-low anodes, an[k] selects digit k
//
// Build option:
//   SEVSEG_LZB_EN  leading-zero blanking: digit k (k=3..1) stays dark while
//                  shadow nibbles k..3 are all zero; digit 0 is always shown.

module sevseg_scan_ctrl #(
  parameter int REFRESH_CNT = 100000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dig_en,
  output logic        upd_pending,
  output logic        frame_done,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  // One timer serves both phases, so it is sized for the longer of the two.
  localparam int MAXC = (REFRESH_CNT > DEAD_CYCLES) ? REFRESH_CNT : DEAD_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] REF_LAST  = TW'(REFRESH_CNT - 1);
  localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [1:0]      idx, idx_nx;
  logic [15:0]     shadow, shadow_nx;
  logic [15:0]     pending, pending_nx;
  logic            upd_nx;
  logic            fd_nx;
  logic [3:0]      an_nx;
  logic [6:0]      seg_nx;
  logic            boundary;
  logic [3:0]      nib;
  logic            lit;
  logic            lzb_ok;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // Sequencing: IDLE -> BLANK -> DRIVE -> BLANK ... ; boundary marks the
  // last DRIVE cycle of digit 3 when scanning continues.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    idx_nx   = idx;
    boundary = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nx = BLANK;
          idx_nx   = 2'd0;
          timer_nx = '0;
        end
      end
      BLANK: begin
        if (!en) begin
          state_nx = IDLE;
          idx_nx   = 2'd0;
          timer_nx = '0;
        end else if (timer == DEAD_LAST) begin
          state_nx = DRIVE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      DRIVE: begin
        if (!en) begin
          state_nx = IDLE;
          idx_nx   = 2'd0;
          timer_nx = '0;
        end else if (timer == REF_LAST) begin
          state_nx = BLANK;
          idx_nx   = idx + 2'd1;
          timer_nx = '0;
          boundary = (idx == 2'd3);
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 2'd0;
        timer_nx = '0;
      end
    endcase
  end

  // Double buffer. A load landing exactly on the boundary bypasses pending
  // and goes straight to the shadow register.
  always_comb begin
    shadow_nx  = shadow;
    pending_nx = pending;
    upd_nx     = upd_pending;
    if (load) begin
      pending_nx = value;
    end
    if (boundary) begin
      if (load) begin
        shadow_nx = value;
      end else if (upd_pending) begin
        shadow_nx = pending;
      end
      upd_nx = 1'b0;
    end else if (load) begin
      upd_nx = 1'b1;
    end
  end

  // Digit selection for the slot being entered. The shadow register can only
  // change on the boundary edge, which always enters BLANK, so the current
  // shadow is the one shown by any DRIVE slot entered on this edge.
  always_comb begin
    nib    = 4'h0;
    lzb_ok = 1'b1;
    case (idx_nx)
      2'd0: begin nib = shadow[3:0];   lzb_ok = 1'b1;            end
      2'd1: begin nib = shadow[7:4];   lzb_ok = |shadow[15:4];   end
      2'd2: begin nib = shadow[11:8];  lzb_ok = |shadow[15:8];   end
      default: begin nib = shadow[15:12]; lzb_ok = |shadow[15:12]; end
    endcase
  end

`ifdef SEVSEG_LZB_EN
  assign lit = dig_en[idx_nx] & lzb_ok;
`else
  assign lit = dig_en[idx_nx];
`endif

  // Outputs are computed for the state being entered, so the registered
  // values line up with the state register.
  always_comb begin
    an_nx  = 4'hF;
    seg_nx = 7'h7F;
    fd_nx  = 1'b0;
    if (state_nx == DRIVE) begin
      if (lit) begin
        an_nx  = ~(4'b0001 << idx_nx);
        seg_nx = hex_to_seg(nib);
      end
      fd_nx = (idx_nx == 2'd3) && (timer_nx == REF_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      idx         <= 2'd0;
      shadow      <= 16'h0000;
      pending     <= 16'h0000;
      upd_pending <= 1'b0;
      frame_done  <= 1'b0;
      an          <= 4'hF;
      seg         <= 7'h7F;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      idx         <= idx_nx;
      shadow      <= shadow_nx;
      pending     <= pending_nx;
      upd_pending <= upd_nx;
      frame_done  <= fd_nx;
      an          <= an_nx;
      seg         <= seg_nx;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// tb/tb_sevseg_scan_ctrl.sv - directed self-checking bench for sevseg_scan_ctrl

module tb_sevseg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dig_en;
  logic        upd_pending;
  logic        frame_done;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_tests;
  int n_fail;
  int ph;
  int cur_c;
  int s_ph;
  logic [3:0] s_an;
  logic [6:0] s_seg;
  logic       s_fd;
  logic       s_up;

  // REFRESH_CNT=5, DEAD_CYCLES=2: 7-cycle slot, 28-cycle frame.
  sevseg_scan_ctrl #(.REFRESH_CNT(5), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .load(load),
    .dig_en(dig_en), .upd_pending(upd_pending), .frame_done(frame_done),
    .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] h);
    case (h)
      4'h0: dec = 7'h40; 4'h1: dec = 7'h79; 4'h2: dec = 7'h24; 4'h3: dec = 7'h30;
      4'h4: dec = 7'h19; 4'h5: dec = 7'h12; 4'h6: dec = 7'h02; 4'h7: dec = 7'h78;
      4'h8: dec = 7'h00; 4'h9: dec = 7'h10; 4'hA: dec = 7'h08; 4'hB: dec = 7'h03;
      4'hC: dec = 7'h46; 4'hD: dec = 7'h21; 4'hE: dec = 7'h06; default: dec = 7'h0E;
    endcase
  endfunction

  // Expected anodes at frame phase c: two dark cycles then five driven.
  function automatic logic [3:0] exp_an(input int c, input logic [3:0] lit);
    int slot;
    int pos;
    slot = c / 7;
    pos  = c % 7;
    if (pos < 2 || !lit[slot]) return 4'hF;
    return ~(4'b0001 << slot);
  endfunction

  function automatic logic [6:0] exp_seg(input int c, input logic [15:0] v);
    int slot;
    int pos;
    slot = c / 7;
    pos  = c % 7;
    if (pos < 2) return 7'h7F;
    return dec(v[slot*4 +: 4]);
  endfunction

  // One clock; samples outputs at the falling edge and drops any load pulse.
  task automatic step();
    @(negedge clk);
    load  = 1'b0;
    s_an  = an;
    s_seg = seg;
    s_fd  = frame_done;
    s_up  = upd_pending;
    s_ph  = ph;
    cur_c = ph % 28;
    ph    = ph + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = 16'h0; dig_en = 4'hF;
    ph = 0;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (an !== 4'hF)  begin n_fail++; $display("FAIL reset_an got=%h exp=F", an); end
    n_tests++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    n_tests++; if (upd_pending !== 1'b0) begin n_fail++; $display("FAIL reset_upd got=%b exp=0", upd_pending); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (s_an !== 4'hF || s_seg !== 7'h7F) begin
        n_fail++; $display("FAIL idle_dark got an=%h seg=%h exp an=F seg=7f", s_an, s_seg);
      end
    end
  endtask

  task automatic test_first_frames();
    logic [15:0] v;
    en = 1'b1; load = 1'b1; value = 16'h1234;
    ph = 0;
    for (int i = 0; i < 56; i++) begin
      step();
      v = (i < 28) ? 16'h0000 : 16'h1234;
      n_tests++; if (s_an !== exp_an(cur_c, 4'hF)) begin
        n_fail++; $display("FAIL first_an ph=%0d got=%h exp=%h", s_ph, s_an, exp_an(cur_c, 4'hF));
      end
      n_tests++; if (s_seg !== exp_seg(cur_c, v)) begin
        n_fail++; $display("FAIL first_seg ph=%0d got=%h exp=%h", s_ph, s_seg, exp_seg(cur_c, v));
      end
      n_tests++; if (s_fd !== (cur_c == 27)) begin
        n_fail++; $display("FAIL first_fd ph=%0d got=%b exp=%b", s_ph, s_fd, cur_c == 27);
      end
      n_tests++; if (s_up !== (i <= 27)) begin
        n_fail++; $display("FAIL first_upd ph=%0d got=%b exp=%b", s_ph, s_up, i <= 27);
      end
    end
  endtask

  task automatic test_midframe_load();
    logic [15:0] v;
    logic        up_exp;
    int fd_a;
    int fd_b;
    fd_a = -1; fd_b = -1;
    for (int i = 0; i < 56; i++) begin
      step();
      v      = (i < 28) ? 16'h1234 : 16'hABCD;
      up_exp = (i < 28) && (cur_c >= 10);
      if (s_fd) begin
        if (fd_a < 0) fd_a = s_ph; else if (fd_b < 0) fd_b = s_ph;
      end
      n_tests++; if (s_an !== exp_an(cur_c, 4'hF) || s_seg !== exp_seg(cur_c, v)) begin
        n_fail++; $display("FAIL mid_disp ph=%0d got an=%h seg=%h exp an=%h seg=%h",
                           s_ph, s_an, s_seg, exp_an(cur_c, 4'hF), exp_seg(cur_c, v));
      end
      n_tests++; if (s_up !== up_exp) begin
        n_fail++; $display("FAIL mid_upd ph=%0d got=%b exp=%b", s_ph, s_up, up_exp);
      end
      if (i == 9) begin load = 1'b1; value = 16'hABCD; end
    end
    n_tests++; if (fd_b - fd_a !== 28) begin
      n_fail++; $display("FAIL frame_period got=%0d exp=28", fd_b - fd_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic        up_exp;
    for (int i = 0; i < 84; i++) begin
      step();
      v      = (i < 28) ? 16'hABCD : ((i < 56) ? 16'h2222 : 16'h9EF8);
      up_exp = (i < 28) && (cur_c >= 5);
      n_tests++; if (s_an !== exp_an(cur_c, 4'hF) || s_seg !== exp_seg(cur_c, v)) begin
        n_fail++; $display("FAIL b2b_disp ph=%0d got an=%h seg=%h exp an=%h seg=%h",
                           s_ph, s_an, s_seg, exp_an(cur_c, 4'hF), exp_seg(cur_c, v));
      end
      n_tests++; if (s_up !== up_exp) begin
        n_fail++; $display("FAIL b2b_upd ph=%0d got=%b exp=%b", s_ph, s_up, up_exp);
      end
      if (i == 4)  begin load = 1'b1; value = 16'h1111; end
      if (i == 14) begin load = 1'b1; value = 16'h2222; end
      if (i == 55) begin
        n_tests++; if (s_fd !== 1'b1) begin
          n_fail++; $display("FAIL coincident_fd ph=%0d got=%b exp=1", s_ph, s_fd);
        end
        load = 1'b1; value = 16'h9EF8;
      end
    end
  endtask

  task automatic test_dig_en();
    int first_e;
    int first_b;
    first_e = -1; first_b = -1;
    dig_en = 4'b0101;
    for (int i = 0; i < 28; i++) begin
      step();
      if (s_an === 4'hE && first_e < 0) first_e = s_ph;
      if (s_an === 4'hB && first_b < 0) first_b = s_ph;
      n_tests++; if (s_an !== exp_an(cur_c, 4'b0101)) begin
        n_fail++; $display("FAIL digen_an ph=%0d got=%h exp=%h", s_ph, s_an, exp_an(cur_c, 4'b0101));
      end
      if (exp_an(cur_c, 4'b0101) != 4'hF) begin
        n_tests++; if (s_seg !== exp_seg(cur_c, 16'h9EF8)) begin
          n_fail++; $display("FAIL digen_seg ph=%0d got=%h exp=%h", s_ph, s_seg, exp_seg(cur_c, 16'h9EF8));
        end
      end
    end
    n_tests++; if (first_b - first_e !== 14) begin
      n_fail++; $display("FAIL digen_timing got=%0d exp=14", first_b - first_e);
    end
    dig_en = 4'hF;
  endtask

  task automatic test_en_drop();
    logic [15:0] v;
    for (int i = 0; i < 18; i++) begin
      step();
      n_tests++; if (s_an !== exp_an(cur_c, 4'hF) || s_seg !== exp_seg(cur_c, 16'h9EF8)) begin
        n_fail++; $display("FAIL pre_drop ph=%0d got an=%h seg=%h", s_ph, s_an, s_seg);
      end
    end
    en = 1'b0;
    step();
    n_tests++; if (s_an !== 4'hF || s_seg !== 7'h7F) begin
      n_fail++; $display("FAIL drop_dark got an=%h seg=%h exp an=F seg=7f", s_an, s_seg);
    end
    load = 1'b1; value = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (s_an !== 4'hF || s_up !== 1'b1 || s_fd !== 1'b0) begin
        n_fail++; $display("FAIL idle_load got an=%h upd=%b fd=%b exp an=F upd=1 fd=0", s_an, s_up, s_fd);
      end
    end
    en = 1'b1;
    ph = 0;
    for (int i = 0; i < 56; i++) begin
      step();
      v = (i < 28) ? 16'h9EF8 : 16'h5678;
      n_tests++; if (s_an !== exp_an(cur_c, 4'hF) || s_seg !== exp_seg(cur_c, v)) begin
        n_fail++; $display("FAIL restart_disp ph=%0d got an=%h seg=%h exp an=%h seg=%h",
                           s_ph, s_an, s_seg, exp_an(cur_c, 4'hF), exp_seg(cur_c, v));
      end
      n_tests++; if (s_up !== (i <= 27)) begin
        n_fail++; $display("FAIL restart_upd ph=%0d got=%b exp=%b", s_ph, s_up, i <= 27);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 11; i++) begin
      step();
      n_tests++; if (s_an !== exp_an(cur_c, 4'hF) || s_seg !== exp_seg(cur_c, 16'h5678)) begin
        n_fail++; $display("FAIL pre_rst ph=%0d got an=%h seg=%h", s_ph, s_an, s_seg);
      end
      if (i == 3) begin load = 1'b1; value = 16'h6666; end
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (an !== 4'hF || seg !== 7'h7F || upd_pending !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got an=%h seg=%h upd=%b fd=%b exp an=F seg=7f upd=0 fd=0",
                         an, seg, upd_pending, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ph = 0;
    for (int i = 0; i < 28; i++) begin
      step();
      n_tests++; if (s_an !== exp_an(cur_c, 4'hF) || s_seg !== exp_seg(cur_c, 16'h0000) || s_up !== 1'b0) begin
        n_fail++; $display("FAIL post_rst ph=%0d got an=%h seg=%h upd=%b exp an=%h seg=%h upd=0",
                           s_ph, s_an, s_seg, s_up, exp_an(cur_c, 4'hF), exp_seg(cur_c, 16'h0000));
      end
    end
  endtask

`ifdef SEVSEG_LZB_EN
  task automatic test_lzb();
    load = 1'b1; value = 16'h0050;
    for (int i = 0; i < 56; i++) begin
      step();
      if (i < 28) begin
        n_tests++; if (s_an !== exp_an(cur_c, 4'b0011)) begin
          n_fail++; $display("FAIL lzb0050_an ph=%0d got=%h exp=%h", s_ph, s_an, exp_an(cur_c, 4'b0011));
        end
        if (exp_an(cur_c, 4'b0011) != 4'hF) begin
          n_tests++; if (s_seg !== exp_seg(cur_c, 16'h0050)) begin
            n_fail++; $display("FAIL lzb0050_seg ph=%0d got=%h exp=%h", s_ph, s_seg, exp_seg(cur_c, 16'h0050));
          end
        end
        if (i == 27) begin load = 1'b1; value = 16'h0000; end
      end else begin
        n_tests++; if (s_an !== exp_an(cur_c, 4'b0001)) begin
          n_fail++; $display("FAIL lzb0000_an ph=%0d got=%h exp=%h", s_ph, s_an, exp_an(cur_c, 4'b0001));
        end
        if (exp_an(cur_c, 4'b0001) != 4'hF) begin
          n_tests++; if (s_seg !== 7'h40) begin
            n_fail++; $display("FAIL lzb0000_seg ph=%0d got=%h exp=40", s_ph, s_seg);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_first_frames();
    test_midframe_load();
    test_back_to_back();
    test_dig_en();
    test_en_drop();
    test_async_reset();
`ifdef SEVSEG_LZB_EN
    test_lzb();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
